// File: rtl/diode_rx_pkg.sv
// Shared definitions for the diode-wave receive checkers.
// Contents: default widths, FSM state encoding, saturating increment helper.
package diode_rx_pkg;

   localparam int DEF_CNT_W  = 16;
   localparam int DEF_TW     = 8;
   localparam int DEF_GATE_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } diode_state_e;

   // Increment that sticks at max_v; callers cast their narrower values to 32 bits and back.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Two-flop synchroniser for an asynchronous pulse wave plus rise/fall detection.
// Ports:
//   clk   in   sampling clock
//   rst   in   asynchronous active-low reset (all flops to 0)
//   d     in   asynchronous input wave
//   s     out  synchronised level
//   rise  out  s went 0->1 this cycle
//   fall  out  s went 1->0 this cycle
module pulse_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic s,
   output logic rise,
   output logic fall
);

   logic meta_q, s_q, prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         s_q    <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d;
         s_q    <= meta_q;
         prev_q <= s_q;
      end
   end

   assign s    = s_q;
   assign rise = s_q & ~prev_q;
   assign fall = ~s_q & prev_q;

endmodule

// File: rtl/diode_pulse_analyzer.sv
// Gated pulse-train checker for the detector output wave.
// Arms on start, samples diode_in for gate_len cycles, then holds the results
// (pulse count, width/dead-time violation counts, last width) until result_ack.
// Ports:
//   clk_200, rst (async active-low)       clock / reset
//   diode_in                              asynchronous detector wave
//   start, gate_len, exp_high_width,
//   exp_deadtime                          arm strobe and configuration latched on it
//   result_ack                            consumer handshake
//   busy, result_valid                    RUN / HOLD indications
//   pulse_count, width_err_count,
//   dt_err_count, last_width, min_gap     measurement results
// Build option: DIODE_GAP_STATS_EN enables min_gap tracking; otherwise min_gap is all-ones.
module diode_pulse_analyzer
   import diode_rx_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TW     = DEF_TW,
   parameter int GATE_W = DEF_GATE_W
) (
   input  logic              clk_200,
   input  logic              rst,
   input  logic              diode_in,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [TW-1:0]     exp_high_width,
   input  logic [TW-1:0]     exp_deadtime,
   input  logic              result_ack,
   output logic              busy,
   output logic              result_valid,
   output logic [CNT_W-1:0]  pulse_count,
   output logic [CNT_W-1:0]  width_err_count,
   output logic [CNT_W-1:0]  dt_err_count,
   output logic [TW-1:0]     last_width,
   output logic [TW-1:0]     min_gap
);

   localparam logic [31:0]       CNT_MAX  = 32'({CNT_W{1'b1}});
   localparam logic [31:0]       TW_MAX   = 32'({TW{1'b1}});
   localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
   localparam logic [TW:0]       TOL_ONE  = (TW+1)'(1);

   logic s, rise, fall;

   pulse_edge_sync u_sync (
      .clk  (clk_200),
      .rst  (rst),
      .d    (diode_in),
      .s    (s),
      .rise (rise),
      .fall (fall)
   );

   diode_state_e      state_q;
   logic              busy_q, valid_q;
   logic [GATE_W-1:0] gate_q;
   logic [TW-1:0]     exp_hw_q, exp_dt_q;

   logic [CNT_W-1:0]  pcnt_q, pcnt_d, werr_q, werr_d, dterr_q, dterr_d;
   logic [TW-1:0]     lastw_q, lastw_d, wt_q, wt_d, gt_q, gt_d;
   logic              have_prev_q, have_prev_d, in_pulse_q, in_pulse_d;
   logic              width_bad;

   // Width check is one bit wider so exp_high_width + 1 cannot wrap.
   assign width_bad = ({1'b0, wt_q} < {1'b0, exp_hw_q}) ||
                      ({1'b0, wt_q} > ({1'b0, exp_hw_q} + TOL_ONE));

   always_ff @(posedge clk_200 or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         gate_q   <= '0;
         exp_hw_q <= '0;
         exp_dt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               exp_hw_q <= exp_high_width;
               exp_dt_q <= exp_deadtime;
               gate_q   <= gate_len;
               if (gate_len == '0) begin
                  state_q <= ST_HOLD;
                  valid_q <= 1'b1;
               end else begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: if (gate_q == GATE_ONE) begin
               state_q <= ST_HOLD;
               busy_q  <= 1'b0;
               valid_q <= 1'b1;
            end else begin
               gate_q <= gate_q - GATE_ONE;
            end
            ST_HOLD: if (result_ack) begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef DIODE_GAP_STATS_EN
   logic [TW-1:0] min_gap_q, min_gap_d;
`endif

   // Timers load 1 on their opening edge so that they hold the full run length
   // (in cycles) when the closing edge arrives.
   always_comb begin
      pcnt_d      = pcnt_q;
      werr_d      = werr_q;
      dterr_d     = dterr_q;
      lastw_d     = lastw_q;
      wt_d        = wt_q;
      gt_d        = gt_q;
      have_prev_d = have_prev_q;
      in_pulse_d  = in_pulse_q;
`ifdef DIODE_GAP_STATS_EN
      min_gap_d   = min_gap_q;
`endif
      if (state_q == ST_IDLE && start) begin
         pcnt_d      = '0;
         werr_d      = '0;
         dterr_d     = '0;
         lastw_d     = '0;
         wt_d        = '0;
         gt_d        = '0;
         have_prev_d = 1'b0;
         in_pulse_d  = 1'b0;
`ifdef DIODE_GAP_STATS_EN
         min_gap_d   = '1;
`endif
      end else if (state_q == ST_RUN) begin
         if (rise) begin
            pcnt_d     = CNT_W'(sat_inc(32'(pcnt_q), CNT_MAX));
            wt_d       = TW'(1);
            in_pulse_d = 1'b1;
            if (have_prev_q) begin
               if (gt_q < exp_dt_q) dterr_d = CNT_W'(sat_inc(32'(dterr_q), CNT_MAX));
`ifdef DIODE_GAP_STATS_EN
               if (gt_q < min_gap_q) min_gap_d = gt_q;
`endif
            end
         end else if (s) begin
            wt_d = TW'(sat_inc(32'(wt_q), TW_MAX));
         end
         if (fall) begin
            gt_d        = TW'(1);
            have_prev_d = 1'b1;
            in_pulse_d  = 1'b0;
            // A pulse already high at arm time has no rise; its width is unknown.
            if (in_pulse_q) begin
               lastw_d = wt_q;
               if (width_bad) werr_d = CNT_W'(sat_inc(32'(werr_q), CNT_MAX));
            end
         end else if (!s) begin
            gt_d = TW'(sat_inc(32'(gt_q), TW_MAX));
         end
      end
   end

   always_ff @(posedge clk_200 or negedge rst) begin
      if (!rst) begin
         pcnt_q      <= '0;
         werr_q      <= '0;
         dterr_q     <= '0;
         lastw_q     <= '0;
         wt_q        <= '0;
         gt_q        <= '0;
         have_prev_q <= 1'b0;
         in_pulse_q  <= 1'b0;
`ifdef DIODE_GAP_STATS_EN
         min_gap_q   <= '1;
`endif
      end else begin
         pcnt_q      <= pcnt_d;
         werr_q      <= werr_d;
         dterr_q     <= dterr_d;
         lastw_q     <= lastw_d;
         wt_q        <= wt_d;
         gt_q        <= gt_d;
         have_prev_q <= have_prev_d;
         in_pulse_q  <= in_pulse_d;
`ifdef DIODE_GAP_STATS_EN
         min_gap_q   <= min_gap_d;
`endif
      end
   end

   assign busy            = busy_q;
   assign result_valid    = valid_q;
   assign pulse_count     = pcnt_q;
   assign width_err_count = werr_q;
   assign dt_err_count    = dterr_q;
   assign last_width      = lastw_q;
`ifdef DIODE_GAP_STATS_EN
   assign min_gap         = min_gap_q;
`else
   assign min_gap         = '1;
`endif

endmodule
